gray_conv_arbiter: RTL and testbench

- Shares one binary-to-Gray conversion datapath (g = b ^ (b >> 1)) among four requesters.
- Uses round-robin arbitration and valid/ready handshakes on both sides.
- Holds the converted result in a single registered output stage with backpressure.
- Sits between multiple pointer or encoder producers and a common Gray-code consumer, such as a CDC pointer path or a display/encoder stage.

---
 rtl/gray_conv_arbiter_if.sv | 23 ++
 rtl/gray_conv_arbiter.sv | 79 +++++++
 tb/tb_gray_conv_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gray_conv_arbiter_if.sv
// rtl/gray_conv_arbiter_if.sv - request and result handshake bundle for gray_conv_arbiter
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_bin;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_gray;
  logic [WIDTH-1:0]   out_bin;
  logic [1:0]         out_id;

  modport master (
    output req_valid, req_bin, out_ready,
    input  req_ready, out_valid, out_gray, out_bin, out_id
  );

  modport slave (
    input  req_valid, req_bin, out_ready,
    output req_ready, out_valid, out_gray, out_bin, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - four-way round-robin arbiter feeding one binary-to-Gray stage
module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_arbiter_if.slave   bus
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic [1:0]       out_id_q, out_id_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic             can_accept;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       probe_idx;
  logic [WIDTH-1:0] sel_bin;
  logic             accept;

  assign can_accept = !out_valid_q || bus.out_ready;

  // First set req_valid bit at or after rr_ptr, wrapping mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    probe_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      probe_idx = rr_ptr_q + 2'(k);
      if (!grant_found && bus.req_valid[probe_idx]) begin
        grant_found = 1'b1;
        grant_idx   = probe_idx;
      end
    end
  end

  assign accept        = !rst && can_accept && grant_found;
  assign bus.req_ready = accept ? (4'b0001 << grant_idx) : 4'b0000;
  assign sel_bin       = bus.req_bin[grant_idx*WIDTH +: WIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_gray_d  = out_gray_q;
    out_bin_d   = out_bin_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_gray_d  = sel_bin ^ (sel_bin >> 1);
      out_bin_d   = sel_bin;
      out_id_d    = grant_idx;
      rr_ptr_d    = grant_idx + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_gray_q  <= '0;
      out_bin_q   <= '0;
      out_id_q    <= 2'd0;
      rr_ptr_q    <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_gray_q  <= out_gray_d;
      out_bin_q   <= out_bin_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_gray  = out_gray_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - directed vector bench for gray_conv_arbiter
module tb_gray_conv_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gray_conv_arbiter_if #(.WIDTH(4)) bus ();

  gray_conv_arbiter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  rv;
    logic [15:0] bin;
    logic        ordy;
    logic [3:0]  exp_rr;
    logic        exp_ov;
    logic [3:0]  exp_g;
    logic [3:0]  exp_b;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t tab[$];
  logic [3:0] gray_ref[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  function automatic vec_t mk(logic r, logic [3:0] rv, logic [15:0] bin, logic ordy,
                              logic [3:0] rr, logic ov, logic [3:0] g, logic [3:0] b,
                              logic [1:0] id);
    vec_t v;
    v = '{r, rv, bin, ordy, rr, ov, g, b, id};
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; req_ready is sampled mid-cycle, registers 1ns after the next edge.
  task automatic apply(vec_t v, int idx);
    rst           = v.rst;
    bus.req_valid = v.rv;
    bus.req_bin   = v.bin;
    bus.out_ready = v.ordy;
    #4;
    chk("req_ready", idx, 16'(bus.req_ready), 16'(v.exp_rr));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 16'(bus.out_valid), 16'(v.exp_ov));
    chk("out_gray",  idx, 16'(bus.out_gray),  16'(v.exp_g));
    chk("out_bin",   idx, 16'(bus.out_bin),   16'(v.exp_b));
    chk("out_id",    idx, 16'(bus.out_id),    16'(v.exp_id));
  endtask

  initial begin
    logic [3:0] prev_g;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_bin   = 16'h0000;
    bus.out_ready = 1'b0;

    // reset with all requesters valid
    tab.push_back(mk(1, 4'b1111, 16'h0000, 1, 4'b0000, 0, 4'h0, 4'h0, 2'd0));
    tab.push_back(mk(1, 4'b1111, 16'h0000, 1, 4'b0000, 0, 4'h0, 4'h0, 2'd0));
    // single request from requester 1, then drain
    tab.push_back(mk(0, 4'b0010, 16'h0050, 1, 4'b0010, 1, 4'h7, 4'h5, 2'd1));
    tab.push_back(mk(0, 4'b0000, 16'h0050, 1, 4'b0000, 0, 4'h7, 4'h5, 2'd1));
    // round-robin with operands 0,3,8,15
    tab.push_back(mk(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 4'h0, 2'd0));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0001, 1, 4'h0, 4'h0, 2'd0));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0010, 1, 4'h2, 4'h3, 2'd1));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0100, 1, 4'hC, 4'h8, 2'd2));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b1000, 1, 4'h8, 4'hF, 2'd3));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0001, 1, 4'h0, 4'h0, 2'd0));
    // backpressure: load id2/gray 0110, stall 3 cycles with req_valid=1011, release
    tab.push_back(mk(0, 4'b0100, 16'h0400, 1, 4'b0100, 1, 4'h6, 4'h4, 2'd2));
    tab.push_back(mk(0, 4'b1011, 16'h9415, 0, 4'b0000, 1, 4'h6, 4'h4, 2'd2));
    tab.push_back(mk(0, 4'b1011, 16'h9415, 0, 4'b0000, 1, 4'h6, 4'h4, 2'd2));
    tab.push_back(mk(0, 4'b1011, 16'h9415, 0, 4'b0000, 1, 4'h6, 4'h4, 2'd2));
    tab.push_back(mk(0, 4'b1011, 16'h9415, 1, 4'b1000, 1, 4'hD, 4'h9, 2'd3));

    @(posedge clk);
    #1;
    foreach (tab[i]) apply(tab[i], i);

    // exhaustive sweep on requester 2, adjacent codes must differ in one bit
    prev_g = 4'h0;
    for (int b = 0; b < 16; b++) begin
      apply(mk(0, 4'b0100, {4'h0, 4'(b), 8'h00}, 1, 4'b0100, 1, gray_ref[b], 4'(b), 2'd2), 100 + b);
      if (b > 0) begin
        checks++;
        if ($countones(bus.out_gray ^ prev_g) != 1) begin
          errors++;
          $display("FAIL gray_adjacent vec %0d: got %h after %h want one-bit change", 100 + b, bus.out_gray, prev_g);
        end
      end
      prev_g = bus.out_gray;
    end

    // reset while stalled with rr_ptr=2, next grant restarts at requester 0
    tab.delete();
    tab.push_back(mk(0, 4'b0010, 16'h0030, 1, 4'b0010, 1, 4'h2, 4'h3, 2'd1));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 0, 4'b0000, 1, 4'h2, 4'h3, 2'd1));
    tab.push_back(mk(1, 4'b1111, 16'hF830, 0, 4'b0000, 0, 4'h0, 4'h0, 2'd0));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0001, 1, 4'h0, 4'h0, 2'd0));
    tab.push_back(mk(0, 4'b1111, 16'hF830, 1, 4'b0010, 1, 4'h2, 4'h3, 2'd1));
    foreach (tab[i]) apply(tab[i], 200 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
